// File: rtl/status_flags.sv
// Processor status register {N,V,M,X,D,I,Z,C} plus the emulation flag, with ALU-flag, mask and mode-switch updates.
// P/E/XH_CLR change one edge after an enabled op; M16, X16 and P_PUSH are combinational from the registered state.
module status_flags #(
  parameter logic [7:0] RESET_P = 8'h34
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] P_OP,
  input  logic [7:0] DI,
  input  logic [2:0] FLG_SEL,
  input  logic       FLG_VAL,
  input  logic       B_IN,
  input  logic       CO,
  input  logic       VO,
  input  logic       SO,
  input  logic       ZO,
  output logic [7:0] P,
  output logic       E,
  output logic       M16,
  output logic       X16,
  output logic [7:0] P_PUSH,
  output logic       XH_CLR
);

  typedef enum logic [3:0] {
    OP_HOLD   = 4'd0,
    OP_NZ     = 4'd1,
    OP_NZC    = 4'd2,
    OP_NZCV   = 4'd3,
    OP_Z      = 4'd4,
    OP_NVZ    = 4'd5,
    OP_SEP    = 4'd6,
    OP_REP    = 4'd7,
    OP_PLP    = 4'd8,
    OP_FLG    = 4'd9,
    OP_XCE    = 4'd10,
    OP_INT    = 4'd11
  } op_e;

  localparam int unsigned BN = 7;
  localparam int unsigned BV = 6;
  localparam int unsigned BM = 5;
  localparam int unsigned BX = 4;
  localparam int unsigned BD = 3;
  localparam int unsigned BI = 2;
  localparam int unsigned BZ = 1;
  localparam int unsigned BC = 0;

  logic [7:0] p_q;
  logic [7:0] p_nxt;
  logic       e_q;
  logic       e_nxt;
  logic       xh_q;
  logic       upd;
  logic       x_rise;
  op_e        op;

  assign op = op_e'(P_OP);

  always_comb begin
    p_nxt = p_q;
    e_nxt = e_q;
    upd   = 1'b0;
    if (EN) begin
      upd = 1'b1;
      case (op)
        OP_NZ: begin
          p_nxt[BN] = SO;
          p_nxt[BZ] = ZO;
        end
        OP_NZC: begin
          p_nxt[BN] = SO;
          p_nxt[BZ] = ZO;
          p_nxt[BC] = CO;
        end
        OP_NZCV: begin
          p_nxt[BN] = SO;
          p_nxt[BZ] = ZO;
          p_nxt[BC] = CO;
          p_nxt[BV] = VO;
        end
        OP_Z: p_nxt[BZ] = ZO;
        OP_NVZ: begin
          p_nxt[BN] = SO;
          p_nxt[BV] = VO;
          p_nxt[BZ] = ZO;
        end
        OP_SEP: p_nxt = p_q | DI;
        OP_REP: p_nxt = p_q & ~DI;
        OP_PLP: p_nxt = DI;
        OP_FLG: p_nxt[FLG_SEL] = FLG_VAL;
        OP_XCE: begin
          p_nxt[BC] = e_q;
          e_nxt     = p_q[BC];
        end
        OP_INT: begin
          p_nxt[BI] = 1'b1;
          p_nxt[BD] = 1'b0;
        end
        default: upd = 1'b0;
      endcase
      // Emulation mode pins the register widths to 8 bits no matter what was written.
      if (upd && e_nxt) begin
        p_nxt[BM] = 1'b1;
        p_nxt[BX] = 1'b1;
      end
    end
  end

  // Narrowing the index registers must also drop their high bytes, one cycle later.
  assign x_rise = ~p_q[BX] & p_nxt[BX];

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q  <= RESET_P;
      e_q  <= 1'b1;
      xh_q <= 1'b0;
    end else begin
      p_q  <= p_nxt;
      e_q  <= e_nxt;
      xh_q <= x_rise;
    end
  end

  assign P      = p_q;
  assign E      = e_q;
  assign M16    = ~p_q[BM];
  assign X16    = ~p_q[BX];
  assign XH_CLR = xh_q;
  assign P_PUSH = e_q ? {p_q[BN], p_q[BV], 1'b1, B_IN, p_q[BD], p_q[BI], p_q[BZ], p_q[BC]} : p_q;

endmodule

// File: tb/tb_status_flags.sv
// Scoreboarded bench for status_flags: directed scenarios then random ops against a flag-level model.
module tb_status_flags;

  localparam logic [7:0] RST_VAL = 8'h34;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] P_OP = 4'd0;
  logic [7:0] DI = 8'h00;
  logic [2:0] FLG_SEL = 3'd0;
  logic       FLG_VAL = 1'b0;
  logic       B_IN = 1'b0;
  logic       CO = 1'b0;
  logic       VO = 1'b0;
  logic       SO = 1'b0;
  logic       ZO = 1'b0;
  logic [7:0] P;
  logic       E;
  logic       M16;
  logic       X16;
  logic [7:0] P_PUSH;
  logic       XH_CLR;

  status_flags #(.RESET_P(RST_VAL)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .P_OP(P_OP), .DI(DI), .FLG_SEL(FLG_SEL),
    .FLG_VAL(FLG_VAL), .B_IN(B_IN), .CO(CO), .VO(VO), .SO(SO), .ZO(ZO),
    .P(P), .E(E), .M16(M16), .X16(X16), .P_PUSH(P_PUSH), .XH_CLR(XH_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] p;
    logic       e;
    logic       xh;
    logic [7:0] push;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: the status byte and emulation bit as the architecture defines them.
  bit [7:0] mp = RST_VAL;
  bit       me = 1'b1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Which P bits each ALU-result op writes, taken from an ALU image {SO,VO,-,-,-,-,ZO,CO}.
  function automatic bit [7:0] alu_mask(input bit [3:0] op);
    case (op)
      4'd1:    return 8'b1000_0010;
      4'd2:    return 8'b1000_0011;
      4'd3:    return 8'b1100_0011;
      4'd4:    return 8'b0000_0010;
      4'd5:    return 8'b1100_0010;
      default: return 8'h00;
    endcase
  endfunction

  task automatic step(input bit rst, input bit en, input bit [3:0] op, input bit [7:0] di,
                      input bit [2:0] sel, input bit val, input bit b,
                      input bit co, input bit vo, input bit so, input bit zo);
    bit [7:0] np;
    bit       ne;
    bit       xh;
    bit [7:0] alu;
    exp_t     ex;
    @(negedge CLK);
    RST = rst; EN = en; P_OP = op; DI = di; FLG_SEL = sel; FLG_VAL = val;
    B_IN = b; CO = co; VO = vo; SO = so; ZO = zo;
    xh = 1'b0;
    if (rst) begin
      mp = RST_VAL;
      me = 1'b1;
    end else if (en && op >= 4'd1 && op <= 4'd11) begin
      np  = mp;
      ne  = me;
      alu = {so, vo, 4'b0000, zo, co};
      if (op <= 4'd5) np = (mp & ~alu_mask(op)) | (alu & alu_mask(op));
      else if (op == 4'd6) np = mp | di;
      else if (op == 4'd7) np = mp & ~di;
      else if (op == 4'd8) np = di;
      else if (op == 4'd9) np[sel] = val;
      else if (op == 4'd10) begin
        np[0] = me;
        ne    = mp[0];
      end else begin
        np[2] = 1'b1;
        np[3] = 1'b0;
      end
      if (ne) np = np | 8'h30;
      xh = (mp[4] == 1'b0) && (np[4] == 1'b1);
      mp = np;
      me = ne;
    end
    ex.p    = mp;
    ex.e    = me;
    ex.xh   = xh;
    ex.push = me ? {mp[7:6], 1'b1, b, mp[3:0]} : mp;
    exp_q.push_back(ex);
  endtask

  task automatic op_step(input bit [3:0] op, input bit [7:0] di, input bit b);
    step(1'b0, 1'b1, op, di, 3'd0, 1'b0, b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every edge with a pending expectation is compared after the registers settle.
  initial begin
    exp_t ex;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        chk("P", P, ex.p);
        chk("E", {7'd0, E}, {7'd0, ex.e});
        chk("XH_CLR", {7'd0, XH_CLR}, {7'd0, ex.xh});
        chk("M16", {7'd0, M16}, {7'd0, ~ex.p[5]});
        chk("X16", {7'd0, X16}, {7'd0, ~ex.p[4]});
        chk("P_PUSH", P_PUSH, ex.push);
      end
    end
  end

  initial begin
    int r;
    // Reset state and push image with both break values.
    step(1'b1, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd8, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op_step(4'd0, 8'h00, 1'b0);
    // XCE to native, REP clears M/X and C, then SEP X twice.
    op_step(4'd10, 8'h00, 1'b0);
    op_step(4'd7, 8'h31, 1'b0);
    op_step(4'd6, 8'h10, 1'b0);
    op_step(4'd0, 8'h00, 1'b0);
    op_step(4'd6, 8'h10, 1'b0);
    op_step(4'd0, 8'h00, 1'b0);
    // SEC then XCE back to emulation.
    op_step(4'd8, 8'h00, 1'b0);
    step(1'b0, 1'b1, 4'd9, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op_step(4'd10, 8'h00, 1'b0);
    op_step(4'd0, 8'h00, 1'b0);
    // Emulation PLP cannot narrow M/X and raises no XH_CLR.
    op_step(4'd8, 8'h00, 1'b0);
    op_step(4'd7, 8'h30, 1'b0);
    op_step(4'd8, 8'hC3, 1'b1);
    op_step(4'd0, 8'h00, 1'b0);
    // Back to native, then ALU-flag ops.
    step(1'b0, 1'b1, 4'd9, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op_step(4'd10, 8'h00, 1'b0);
    op_step(4'd8, 8'h00, 1'b0);
    step(1'b0, 1'b1, 4'd5, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'd3, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Interrupt entry disabled, then colliding with reset.
    step(1'b0, 1'b0, 4'd11, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd11, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset discarding a pending XH_CLR pulse.
    op_step(4'd10, 8'h00, 1'b0);
    op_step(4'd7, 8'h10, 1'b0);
    op_step(4'd6, 8'h10, 1'b0);
    step(1'b1, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op_step(4'd0, 8'h00, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      step(r < 2,
           $urandom_range(0, 99) < 80,
           (r < 30) ? 4'(($urandom_range(0, 3) == 0) ? 10 : $urandom_range(6, 9)) : 4'($urandom_range(0, 15)),
           8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge CLK);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
